// File: rtl/stim_resp_harness.sv
// -----------------------------------------------------------------------------
// stim_resp_harness
//
// Stimulus player and response compactor for netlist equivalence fuzzing.
// A small memory holds up to DEPTH input vectors. A run first applies an
// all-zero vector, then vectors mem[0..n-1], each held for HOLD cycles. At the
// last cycle of each hold period the DUT response is captured and folded into
// a MISR signature, so two netlists can be compared by one word.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         begin a run (ignored while busy)
//   num_vec       vectors to play, clamped to DEPTH, sampled with start
//   load_we       memory write strobe (ignored while busy)
//   load_addr     memory write address (addresses >= DEPTH are dropped)
//   load_data     memory write data
//   stim          vector presented to the DUT
//   resp          DUT response
//   resp_valid    one-cycle pulse per captured response
//   resp_q        captured response
//   vec_idx       vector being applied (0 = zero vector, i = mem[i-1])
//   sig           running MISR signature
//   busy          run in progress
//   done          run complete, held until next start or reset
// -----------------------------------------------------------------------------
module stim_resp_harness #(
    parameter int               IN_W  = 75,
    parameter int               OUT_W = 166,
    parameter int               DEPTH = 32,
    parameter int               HOLD  = 1,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
    parameter int               IDX_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] num_vec,
    input  logic             load_we,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [IN_W-1:0]  load_data,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] resp,
    output logic             resp_valid,
    output logic [OUT_W-1:0] resp_q,
    output logic [IDX_W-1:0] vec_idx,
    output logic [SIG_W-1:0] sig,
    output logic             busy,
    output logic             done
);

    // Memory address width: IDX_W carries one extra bit so it can hold DEPTH.
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int NSL   = (OUT_W + SIG_W - 1) / SIG_W;
    localparam int PAD_W = NSL * SIG_W;

    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD - 1);
    localparam logic [IDX_W-1:0] DEPTH_C   = IDX_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ZERO,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [OUT_W-1:0] resp_hold_q, resp_hold_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // ------------------------------------------------------------------
    // Stimulus memory. Read is asynchronous so the next vector can be
    // loaded into stim on the same edge that captures the current one.
    // ------------------------------------------------------------------
    logic [IN_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (load_we && !busy_q && (load_addr < DEPTH_C)) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Response fold: XOR of all SIG_W-bit slices, top slice zero-padded.
    // ------------------------------------------------------------------
    logic [PAD_W-1:0] resp_pad;
    logic [SIG_W-1:0] slice [NSL];
    logic [SIG_W-1:0] fold_v;
    logic [SIG_W-1:0] misr_next;

    assign resp_pad = PAD_W'(resp);

    generate
        for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
            assign slice[gi] = resp_pad[gi*SIG_W +: SIG_W];
        end
    endgenerate

    always_comb begin
        fold_v = '0;
        for (int i = 0; i < NSL; i++) begin
            fold_v = fold_v ^ slice[i];
        end
    end

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? POLY : '0)
                     ^ fold_v;

    logic capture;
    assign capture = (hold_q == HOLD_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        n_d          = n_q;
        vec_idx_d    = vec_idx_q;
        stim_d       = stim_q;
        sig_d        = sig_q;
        resp_hold_d  = resp_hold_q;
        resp_valid_d = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = ZERO;
                    sig_d     = '0;
                    vec_idx_d = '0;
                    hold_d    = '0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    stim_d    = '0;
                    n_d       = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
                end
            end

            ZERO, RUN: begin
                if (capture) begin
                    resp_hold_d  = resp;
                    resp_valid_d = 1'b1;
                    sig_d        = misr_next;
                    hold_d       = '0;
                    // In ZERO vec_idx is 0, so the same test covers both the
                    // n=0 exit and the ordinary "more vectors left" case.
                    if (vec_idx_q < n_q) begin
                        state_d   = RUN;
                        stim_d    = mem[vec_idx_q[AW-1:0]];
                        vec_idx_d = vec_idx_q + 1'b1;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stim_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            n_q          <= '0;
            vec_idx_q    <= '0;
            stim_q       <= '0;
            sig_q        <= '0;
            resp_hold_q  <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            n_q          <= n_d;
            vec_idx_q    <= vec_idx_d;
            stim_q       <= stim_d;
            sig_q        <= sig_d;
            resp_hold_q  <= resp_hold_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign stim       = stim_q;
    assign resp_valid = resp_valid_q;
    assign resp_q     = resp_hold_q;
    assign vec_idx    = vec_idx_q;
    assign sig        = sig_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_stim_resp_harness.sv
// -----------------------------------------------------------------------------
// Testbench for stim_resp_harness. Two loopback instances (HOLD=1 and HOLD=3,
// resp tied to stim) share one stimulus stream. Issuing a run pushes the
// expected captures (cycle, value, signature) into a per-instance queue; a
// negedge monitor pops them when resp_valid appears and also checks the
// per-cycle busy/done/stim/vec_idx timeline against the run description.
// -----------------------------------------------------------------------------
module tb_stim_resp_harness;

    typedef struct {
        int         cyc;
        logic [7:0] r;
        logic [7:0] s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] num_vec = '0;
    logic       load_we = 1'b0;
    logic [2:0] load_addr = '0;
    logic [7:0] load_data = '0;

    logic [7:0] stim_w    [2];
    logic [7:0] resp_q_w  [2];
    logic [7:0] sig_w     [2];
    logic [2:0] vec_idx_w [2];
    logic       rv_w      [2];
    logic       busy_w    [2];
    logic       done_w    [2];

    exp_t       sbq [2][$];
    logic [7:0] mem_m [4];
    logic [7:0] run_vecs [5];
    logic [7:0] final_sig [2];
    int         run_k = 0;
    int         run_n = 0;
    bit         run_on = 1'b0;
    int         cycle_cnt = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] ref_sig;

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    stim_resp_harness #(
        .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(1), .SIG_W(8), .POLY(8'h1D)
    ) u_dut_h1 (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .stim(stim_w[0]), .resp(stim_w[0]), .resp_valid(rv_w[0]),
        .resp_q(resp_q_w[0]), .vec_idx(vec_idx_w[0]), .sig(sig_w[0]),
        .busy(busy_w[0]), .done(done_w[0])
    );

    stim_resp_harness #(
        .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(3), .SIG_W(8), .POLY(8'h1D)
    ) u_dut_h3 (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .stim(stim_w[1]), .resp(stim_w[1]), .resp_valid(rv_w[1]),
        .resp_q(resp_q_w[1]), .vec_idx(vec_idx_w[1]), .sig(sig_w[1]),
        .busy(busy_w[1]), .done(done_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    // Signature step from its arithmetic definition: double modulo 256,
    // add the polynomial when the top bit fell off, then mix in the response.
    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] r);
        int v;
        v = (int'(s) * 2) % 256;
        if (int'(s) >= 128) v = v ^ 32'h1D;
        v = v ^ int'(r);
        return 8'(v);
    endfunction

    function automatic int hold_of(input int h);
        return (h == 0) ? 1 : 3;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        int   hh;
        int   jj;
        int   end_c;
        exp_t e;
        for (int h = 0; h < 2; h++) begin
            hh = hold_of(h);
            if (rv_w[h] === 1'b1) begin
                if (sbq[h].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp_valid H%0d: got resp_q %0h, expected no pulse (cycle %0d)",
                             hh, resp_q_w[h], cycle_cnt);
                end else begin
                    e = sbq[h].pop_front();
                    chk($sformatf("H%0d_capture_cycle", hh), 32'(cycle_cnt), 32'(e.cyc));
                    chk($sformatf("H%0d_resp_q", hh), 32'(resp_q_w[h]), 32'(e.r));
                    chk($sformatf("H%0d_sig", hh), 32'(sig_w[h]), 32'(e.s));
                end
            end else if (run_on && sbq[h].size() > 0 && sbq[h][0].cyc <= cycle_cnt) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_resp_valid H%0d: got no pulse, expected capture of %0h at cycle %0d",
                         hh, sbq[h][0].r, sbq[h][0].cyc);
                e = sbq[h].pop_front();
            end
            if (run_on && cycle_cnt >= run_k) begin
                jj    = (cycle_cnt - run_k) / hh;
                end_c = run_k + (run_n + 1) * hh;
                chk($sformatf("H%0d_busy", hh), 32'(busy_w[h]), 32'(cycle_cnt < end_c));
                chk($sformatf("H%0d_done", hh), 32'(done_w[h]), 32'(cycle_cnt >= end_c));
                chk($sformatf("H%0d_stim", hh), 32'(stim_w[h]),
                    (cycle_cnt >= end_c) ? 32'h0 : 32'(run_vecs[jj]));
                chk($sformatf("H%0d_vec_idx", hh), 32'(vec_idx_w[h]),
                    32'((jj < run_n) ? jj : run_n));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int a, input logic [7:0] d);
        tick();
        load_we   = 1'b1;
        load_addr = 3'(a);
        load_data = d;
        if (a < 4) mem_m[a] = d;
        tick();
        load_we = 1'b0;
    endtask

    task automatic start_run(input int nv, input bit do_load, input int a, input logic [7:0] d);
        int         n;
        logic [7:0] s;
        tick();
        start   = 1'b1;
        num_vec = 3'(nv);
        if (do_load) begin
            load_we   = 1'b1;
            load_addr = 3'(a);
            load_data = d;
            if (a < 4) mem_m[a] = d;
        end
        n = (nv > 4) ? 4 : nv;
        run_vecs[0] = 8'h00;
        for (int j = 1; j <= n; j++) run_vecs[j] = mem_m[j-1];
        for (int h = 0; h < 2; h++) begin
            s = 8'h00;
            for (int j = 0; j <= n; j++) begin
                s = misr_ref(s, run_vecs[j]);
                sbq[h].push_back('{cycle_cnt + 1 + (j + 1) * hold_of(h), run_vecs[j], s});
            end
            final_sig[h] = s;
        end
        run_k  = cycle_cnt + 1;
        run_n  = n;
        run_on = 1'b1;
        $display("run: num_vec=%0d n=%0d vectors=%h %h %h %h expected sig=%h",
                 nv, n, mem_m[0], mem_m[1], mem_m[2], mem_m[3], final_sig[0]);
        tick();
        start   = 1'b0;
        load_we = 1'b0;
    endtask

    task automatic wait_run();
        repeat ((run_n + 1) * 3 + 2) tick();
        for (int h = 0; h < 2; h++) begin
            chk($sformatf("H%0d_end_done", hold_of(h)), 32'(done_w[h]), 32'h1);
            chk($sformatf("H%0d_end_busy", hold_of(h)), 32'(busy_w[h]), 32'h0);
            chk($sformatf("H%0d_end_sig", hold_of(h)), 32'(sig_w[h]), 32'(final_sig[h]));
            chk($sformatf("H%0d_pending_captures", hold_of(h)), 32'(sbq[h].size()), 32'h0);
        end
    endtask

    task automatic check_reset();
        for (int h = 0; h < 2; h++) begin
            chk($sformatf("H%0d_rst_stim", hold_of(h)), 32'(stim_w[h]), 32'h0);
            chk($sformatf("H%0d_rst_resp_valid", hold_of(h)), 32'(rv_w[h]), 32'h0);
            chk($sformatf("H%0d_rst_resp_q", hold_of(h)), 32'(resp_q_w[h]), 32'h0);
            chk($sformatf("H%0d_rst_vec_idx", hold_of(h)), 32'(vec_idx_w[h]), 32'h0);
            chk($sformatf("H%0d_rst_sig", hold_of(h)), 32'(sig_w[h]), 32'h0);
            chk($sformatf("H%0d_rst_busy", hold_of(h)), 32'(busy_w[h]), 32'h0);
            chk($sformatf("H%0d_rst_done", hold_of(h)), 32'(done_w[h]), 32'h0);
        end
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
        repeat (3) tick();
        check_reset();
        rst = 1'b0;
        // Memory is not reset, so define every entry before relying on it.
        for (int i = 0; i < 4; i++) load(i, 8'h00);

        // Basic sequence 00,01,02,03 -> sig 03
        load(0, 8'h01);
        load(1, 8'h02);
        load(2, 8'h03);
        start_run(3, 1'b0, 0, 8'h00);
        wait_run();
        chk("plan_sig_010203", 32'(sig_w[0]), 32'h03);

        // MSB feedback path -> sig 9D
        load(0, 8'h80);
        load(1, 8'h80);
        start_run(2, 1'b0, 0, 8'h00);
        wait_run();
        chk("plan_sig_8080", 32'(sig_w[1]), 32'h9D);

        // Zero vectors: single capture of 00
        start_run(0, 1'b0, 0, 8'h00);
        wait_run();
        chk("plan_sig_n0", 32'(sig_w[0]), 32'h00);

        // Clamp 7 -> 4, plus a dropped out-of-range write
        for (int i = 0; i < 4; i++) load(i, 8'($urandom));
        load(5, 8'hEE);
        load(4, 8'hEE);
        start_run(7, 1'b0, 0, 8'h00);
        wait_run();

        // start and load_we while busy are ignored
        start_run(3, 1'b0, 0, 8'h00);
        tick();
        tick();
        start     = 1'b1;
        num_vec   = 3'd1;
        load_we   = 1'b1;
        load_addr = 3'd0;
        load_data = 8'hAA;
        tick();
        start   = 1'b0;
        load_we = 1'b0;
        wait_run();
        start_run(3, 1'b0, 0, 8'h00);
        wait_run();

        // Load on the same edge as start is used by that run
        start_run(2, 1'b1, 0, 8'($urandom));
        wait_run();

        // Abort mid-run with rst, then replay
        start_run(4, 1'b0, 0, 8'h00);
        wait_run();
        ref_sig = final_sig[0];
        start_run(4, 1'b0, 0, 8'h00);
        repeat (3) tick();
        rst    = 1'b1;
        run_on = 1'b0;
        tick();
        check_reset();
        rst = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        start_run(4, 1'b0, 0, 8'h00);
        wait_run();
        chk("replay_sig_H1", 32'(sig_w[0]), 32'(ref_sig));
        chk("replay_sig_H3", 32'(sig_w[1]), 32'(ref_sig));

        // Randomized runs
        for (int it = 0; it < 8; it++) begin
            repeat (3) load(int'($urandom_range(0, 7)), 8'($urandom));
            start_run(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)), 8'($urandom));
            wait_run();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
